// File: rtl/route_scheduler.sv
// Round-robin scheduler granting one (rank, channel) target at a time to the RCD signal router.
// Ganged mode folds both subchannels of a rank into one grant; errors are reported as one-cycle pulses.
module route_scheduler #(
    parameter int NUM_RANKS      = 2,
    parameter int NUM_CHANNELS   = 2,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int RW = (NUM_RANKS > 1) ? $clog2(NUM_RANKS) : 1,
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int NT = NUM_RANKS * NUM_CHANNELS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_gang_mode,
    input  logic [NUM_RANKS-1:0]    cfg_rank_en,
    input  logic [NUM_CHANNELS-1:0] cfg_channel_en,
    input  logic [NT-1:0]           req_valid,
    output logic [NT-1:0]           req_ready,
    output logic                    sched_valid,
    output logic [RW-1:0]           sched_rank,
    output logic [CW-1:0]           sched_channel,
    output logic                    sched_gang,
    input  logic                    route_ack,
    output logic                    busy,
    output logic                    err_disabled,
    output logic                    err_timeout,
    output logic                    err_spurious_ack,
    output logic [15:0]             grant_count
);
    localparam int PW = (NT > 1) ? $clog2(NT) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [15:0]     count_q, count_d;
    logic [RW-1:0]   rank_q, rank_d;
    logic [CW-1:0]   chan_q, chan_d;
    logic            gang_q, gang_d;
    logic            abort_q, abort_d;
    logic            timeout_q, timeout_d;
    logic            spur_q, spur_d;

    logic [NT-1:0]        legal;
    logic [NT-1:0]        legal_req;
    logic [NT-1:0]        drop_mask;
    logic [NT-1:0]        gnt_mask;
    logic [NUM_RANKS-1:0] rank_req;
    logic                 found;
    logic [PW-1:0]        gnt_t;
    logic [RW-1:0]        gnt_rank;
    logic [CW-1:0]        gnt_chan;
    logic                 held_legal;
    int                   sel_idx;

    // Legality under the live configuration; only used while IDLE.
    always_comb begin
        legal    = '0;
        rank_req = '0;
        for (int t = 0; t < NT; t++) begin
            legal[t] = cfg_rank_en[t / NUM_CHANNELS] &&
                       (cfg_gang_mode ? (&cfg_channel_en) : cfg_channel_en[t % NUM_CHANNELS]);
        end
        for (int r = 0; r < NUM_RANKS; r++) begin
            rank_req[r] = |(req_valid[r*NUM_CHANNELS +: NUM_CHANNELS] &
                            legal[r*NUM_CHANNELS +: NUM_CHANNELS]);
        end
    end

    assign legal_req = req_valid & legal;
    assign drop_mask = req_valid & ~legal;

    // Round-robin search starting just after the last granted target (or rank).
    always_comb begin
        found    = 1'b0;
        gnt_t    = ptr_q;
        gnt_mask = '0;
        gnt_rank = '0;
        gnt_chan = '0;
        sel_idx  = 0;
        if (cfg_gang_mode) begin
            for (int i = 1; i <= NUM_RANKS; i++) begin
                sel_idx = (int'(ptr_q) / NUM_CHANNELS + i) % NUM_RANKS;
                if (!found && rank_req[sel_idx]) begin
                    found    = 1'b1;
                    gnt_rank = RW'(sel_idx);
                    gnt_t    = PW'(sel_idx * NUM_CHANNELS + NUM_CHANNELS - 1);
                end
            end
            for (int t = 0; t < NT; t++) begin
                if (found && ((t / NUM_CHANNELS) == int'(gnt_rank))) begin
                    gnt_mask[t] = legal_req[t];
                end
            end
        end else begin
            for (int i = 1; i <= NT; i++) begin
                sel_idx = (int'(ptr_q) + i) % NT;
                if (!found && legal_req[sel_idx]) begin
                    found    = 1'b1;
                    gnt_t    = PW'(sel_idx);
                    gnt_rank = RW'(sel_idx / NUM_CHANNELS);
                    gnt_chan = CW'(sel_idx % NUM_CHANNELS);
                end
            end
            if (found) begin
                gnt_mask[gnt_t] = 1'b1;
            end
        end
    end

    // The outstanding command is judged by its latched gang flag, not the live mode bit.
    assign held_legal = cfg_rank_en[rank_q] &&
                        (gang_q ? (&cfg_channel_en) : cfg_channel_en[chan_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(NT - 1);
            timer_q   <= '0;
            count_q   <= '0;
            rank_q    <= '0;
            chan_q    <= '0;
            gang_q    <= 1'b0;
            abort_q   <= 1'b0;
            timeout_q <= 1'b0;
            spur_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            rank_q    <= rank_d;
            chan_q    <= chan_d;
            gang_q    <= gang_d;
            abort_q   <= abort_d;
            timeout_q <= timeout_d;
            spur_q    <= spur_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        count_d   = count_q;
        rank_d    = rank_q;
        chan_d    = chan_q;
        gang_d    = gang_q;
        abort_d   = 1'b0;
        timeout_d = 1'b0;
        spur_d    = 1'b0;
        case (state_q)
            IDLE: begin
                spur_d = route_ack;
                if (found) begin
                    state_d = BUSY;
                    ptr_d   = gnt_t;
                    timer_d = '0;
                    rank_d  = gnt_rank;
                    chan_d  = gnt_chan;
                    gang_d  = cfg_gang_mode;
                end
            end
            BUSY: begin
                // Ack wins over a disable, which wins over the timeout.
                if (route_ack) begin
                    state_d = IDLE;
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end else if (!held_legal) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = '0;
        sched_valid      = 1'b0;
        busy             = 1'b0;
        sched_rank       = '0;
        sched_channel    = '0;
        sched_gang       = 1'b0;
        err_disabled     = 1'b0;
        err_timeout      = 1'b0;
        err_spurious_ack = 1'b0;
        if (!rst) begin
            sched_valid      = (state_q == BUSY);
            busy             = (state_q == BUSY);
            sched_rank       = rank_q;
            sched_channel    = chan_q;
            sched_gang       = gang_q;
            err_timeout      = timeout_q;
            err_spurious_ack = spur_q;
            err_disabled     = abort_q;
            if (state_q == IDLE) begin
                req_ready    = drop_mask | gnt_mask;
                err_disabled = abort_q | (|drop_mask);
            end
        end
    end

    assign grant_count = count_q;

endmodule

// File: tb/tb_route_scheduler.sv
// Directed bench for route_scheduler: table of single-grant vectors plus hand-written
// sequences for reset, timeout, spurious ack, mid-command disable and ack/timeout collision.
module tb_route_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_gang_mode;
    logic [1:0]  cfg_rank_en;
    logic [1:0]  cfg_channel_en;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic        sched_valid;
    logic [0:0]  sched_rank;
    logic [0:0]  sched_channel;
    logic        sched_gang;
    logic        route_ack;
    logic        busy;
    logic        err_disabled;
    logic        err_timeout;
    logic        err_spurious_ack;
    logic [15:0] grant_count;

    int checks   = 0;
    int failures = 0;

    route_scheduler #(
        .NUM_RANKS(2), .NUM_CHANNELS(2), .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk), .rst(rst), .cfg_gang_mode(cfg_gang_mode),
        .cfg_rank_en(cfg_rank_en), .cfg_channel_en(cfg_channel_en),
        .req_valid(req_valid), .req_ready(req_ready),
        .sched_valid(sched_valid), .sched_rank(sched_rank),
        .sched_channel(sched_channel), .sched_gang(sched_gang),
        .route_ack(route_ack), .busy(busy), .err_disabled(err_disabled),
        .err_timeout(err_timeout), .err_spurious_ack(err_spurious_ack),
        .grant_count(grant_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        gang;
        logic [1:0]  rank_en;
        logic [1:0]  chan_en;
        logic [3:0]  req;
        logic [3:0]  exp_ready;
        logic        exp_err;
        logic        exp_grant;
        logic        exp_rank;
        logic        exp_chan;
        logic        exp_gang;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " sched_valid"}, sched_valid, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " req_ready"}, req_ready, 0);
        check({tag, " err_disabled"}, err_disabled, 0);
        check({tag, " err_timeout"}, err_timeout, 0);
        check({tag, " err_spurious_ack"}, err_spurious_ack, 0);
        check({tag, " sched_rank"}, sched_rank, 0);
        check({tag, " sched_channel"}, sched_channel, 0);
        check({tag, " sched_gang"}, sched_gang, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        // gang rank_en chan_en req | ready err grant rank chan gang count
        vecs[0]  = '{0, 2'b11, 2'b11, 4'b1111, 4'b0001, 0, 1, 0, 0, 0, 16'd1};
        vecs[1]  = '{0, 2'b11, 2'b11, 4'b1111, 4'b0010, 0, 1, 0, 1, 0, 16'd2};
        vecs[2]  = '{0, 2'b11, 2'b11, 4'b1111, 4'b0100, 0, 1, 1, 0, 0, 16'd3};
        vecs[3]  = '{0, 2'b11, 2'b11, 4'b1111, 4'b1000, 0, 1, 1, 1, 0, 16'd4};
        vecs[4]  = '{1, 2'b11, 2'b11, 4'b0110, 4'b0010, 0, 1, 0, 0, 1, 16'd5};
        vecs[5]  = '{1, 2'b11, 2'b11, 4'b0110, 4'b0100, 0, 1, 1, 0, 1, 16'd6};
        vecs[6]  = '{0, 2'b11, 2'b11, 4'b1111, 4'b0001, 0, 1, 0, 0, 0, 16'd7};
        vecs[7]  = '{0, 2'b11, 2'b01, 4'b1010, 4'b1010, 1, 0, 0, 0, 0, 16'd7};
        vecs[8]  = '{0, 2'b11, 2'b01, 4'b1011, 4'b1011, 1, 1, 0, 0, 0, 16'd8};
        vecs[9]  = '{0, 2'b10, 2'b11, 4'b0011, 4'b0011, 1, 0, 0, 0, 0, 16'd8};
        vecs[10] = '{1, 2'b11, 2'b01, 4'b1100, 4'b1100, 1, 0, 0, 0, 0, 16'd8};
        vecs[11] = '{1, 2'b11, 2'b11, 4'b1000, 4'b1000, 0, 1, 1, 0, 1, 16'd9};
        vecs[12] = '{0, 2'b10, 2'b11, 4'b1101, 4'b0101, 1, 1, 1, 0, 0, 16'd10};
        vecs[13] = '{0, 2'b11, 2'b11, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 16'd10};

        // Reset: outputs forced low even with pending, all-illegal requests.
        rst = 1'b1; cfg_gang_mode = 1'b0; cfg_rank_en = 2'b00; cfg_channel_en = 2'b11;
        req_valid = 4'b1111; route_ack = 1'b0;
        tick(); tick(); #2;
        check_idle_outputs("in_reset");
        check("in_reset grant_count", grant_count, 0);
        tick();
        rst = 1'b0; req_valid = 4'b0000; cfg_rank_en = 2'b11; #2;
        check_idle_outputs("after_reset");
        check("after_reset grant_count", grant_count, 0);

        for (int i = 0; i < 14; i++) begin
            cfg_gang_mode = vecs[i].gang; cfg_rank_en = vecs[i].rank_en;
            cfg_channel_en = vecs[i].chan_en; req_valid = vecs[i].req; route_ack = 1'b0;
            #2;
            check($sformatf("v%0d req_ready", i), req_ready, vecs[i].exp_ready);
            check($sformatf("v%0d err_disabled", i), err_disabled, vecs[i].exp_err);
            tick();
            req_valid = 4'b0000; #2;
            check($sformatf("v%0d sched_valid", i), sched_valid, vecs[i].exp_grant);
            if (vecs[i].exp_grant) begin
                check($sformatf("v%0d sched_rank", i), sched_rank, vecs[i].exp_rank);
                check($sformatf("v%0d sched_channel", i), sched_channel, vecs[i].exp_chan);
                check($sformatf("v%0d sched_gang", i), sched_gang, vecs[i].exp_gang);
                route_ack = 1'b1;
            end
            tick();
            route_ack = 1'b0; #2;
            check($sformatf("v%0d sched_valid_after", i), sched_valid, 0);
            check($sformatf("v%0d grant_count", i), grant_count, vecs[i].exp_count);
        end

        // Timeout on t=2 with no ack, then a spurious ack in IDLE.
        cfg_gang_mode = 1'b0; cfg_rank_en = 2'b11; cfg_channel_en = 2'b11;
        req_valid = 4'b0100; #2;
        check("timeout req_ready", req_ready, 4'b0100);
        tick();
        req_valid = 4'b0000; #2;
        hi = 0;
        while (sched_valid === 1'b1 && hi < 40) begin
            hi++;
            check("timeout err_timeout_early", err_timeout, 0);
            tick(); #2;
        end
        check("timeout high_cycles", hi, 15);
        check("timeout err_timeout", err_timeout, 1);
        check("timeout grant_count", grant_count, 10);
        route_ack = 1'b1;
        tick();
        route_ack = 1'b0; #2;
        check("timeout pulse_width", err_timeout, 0);
        check("spurious err_spurious_ack", err_spurious_ack, 1);
        check("spurious sched_valid", sched_valid, 0);
        tick(); #2;
        check("spurious pulse_width", err_spurious_ack, 0);
        check("spurious grant_count", grant_count, 10);

        // Disable rank 1 on the second BUSY cycle of a t=3 grant.
        req_valid = 4'b1000; #2;
        check("disable req_ready", req_ready, 4'b1000);
        tick();
        req_valid = 4'b0000; #2;
        check("disable busy1", busy, 1);
        tick();
        cfg_rank_en = 2'b01; #2;
        check("disable busy2", sched_valid, 1);
        tick(); #2;
        check("disable err_disabled", err_disabled, 1);
        check("disable sched_valid", sched_valid, 0);
        check("disable grant_count", grant_count, 10);
        cfg_rank_en = 2'b11;
        tick(); #2;
        check("disable pulse_width", err_disabled, 0);

        // Ack arriving on the timeout cycle counts as completion.
        req_valid = 4'b0001; #2;
        check("collide req_ready", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000;
        for (int k = 1; k < 15; k++) tick();
        route_ack = 1'b1; #2;
        check("collide last_busy", sched_valid, 1);
        tick();
        route_ack = 1'b0; #2;
        check("collide sched_valid", sched_valid, 0);
        check("collide err_timeout", err_timeout, 0);
        check("collide grant_count", grant_count, 11);

        // Reset mid-BUSY together with an ack: command dropped, pointer back to NT-1.
        req_valid = 4'b0010; #2;
        check("rstbusy req_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0000;
        rst = 1'b1; route_ack = 1'b1; #2;
        check("rstbusy in_reset sched_valid", sched_valid, 0);
        check("rstbusy in_reset busy", busy, 0);
        tick();
        rst = 1'b0; route_ack = 1'b0; #2;
        check_idle_outputs("rstbusy after");
        check("rstbusy grant_count", grant_count, 0);
        req_valid = 4'b1111; #2;
        check("rstbusy ptr_restart", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0000; route_ack = 1'b1; #2;
        check("rstbusy sched_rank", sched_rank, 0);
        tick();
        route_ack = 1'b0; #2;
        check("rstbusy final_count", grant_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
